// File: rtl/systolic_feeder_4_if.sv
// Load port of systolic_feeder_4: writes one A row or one B column per cycle.
interface systolic_feeder_4_if #(
   parameter int unsigned data_size = 8
);
   logic                     load_valid;
   logic                     load_sel;
   logic [1:0]               load_idx;
   logic [4*data_size-1:0]   load_data;
   logic                     load_ready;

   modport master (
      output load_valid, load_sel, load_idx, load_data,
      input  load_ready
   );

   modport slave (
      input  load_valid, load_sel, load_idx, load_data,
      output load_ready
   );
endinterface

// File: rtl/systolic_feeder_4.sv
// systolic_feeder_4: holds 4x4 operand matrices A and B and streams them, diagonally
// skewed, into a 4x4 output-stationary systolic array.
// Define SYSTOLIC_FEEDER_DBUF_EN for two A/B banks (load during a run, swap on start).
module systolic_feeder_4 #(
   parameter int unsigned data_size = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   systolic_feeder_4_if.slave   ld,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 array_rst,
   output logic [data_size-1:0] a1,
   output logic [data_size-1:0] a2,
   output logic [data_size-1:0] a3,
   output logic [data_size-1:0] a4,
   output logic [data_size-1:0] b1,
   output logic [data_size-1:0] b2,
   output logic [data_size-1:0] b3,
   output logic [data_size-1:0] b4
);

   typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic                 busy_q, done_q, array_rst_q, ready_q;
   logic                 ready_d;
   logic [data_size-1:0] a_q [4];
   logic [data_size-1:0] a_d [4];
   logic [data_size-1:0] b_q [4];
   logic [data_size-1:0] b_d [4];
   // Bank currently visible to the stream logic
   logic [data_size-1:0] act_a [4][4];
   logic [data_size-1:0] act_b [4][4];
   logic                 load_fire;

   assign load_fire = ld.load_valid && ready_q;

`ifdef SYSTOLIC_FEEDER_DBUF_EN
   // bank_q is the streamed bank; loads always target the other (shadow) bank
   logic                 bank_q;
   logic [data_size-1:0] mat_a_q [2][4][4];
   logic [data_size-1:0] mat_b_q [2][4][4];

   // Shadow-bank writes and bank swap on an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_q <= 1'b0;
         for (int n = 0; n < 2; n++)
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++) begin
                  mat_a_q[n][i][j] <= '0;
                  mat_b_q[n][i][j] <= '0;
               end
      end else begin
         if (state_q == StIdle && start) bank_q <= ~bank_q;
         if (load_fire) begin
            for (int k = 0; k < 4; k++) begin
               if (!ld.load_sel) mat_a_q[~bank_q][ld.load_idx][k] <= ld.load_data[k*data_size +: data_size];
               else              mat_b_q[~bank_q][k][ld.load_idx] <= ld.load_data[k*data_size +: data_size];
            end
         end
      end
   end

   // Select the active bank for streaming
   always_comb begin
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            act_a[i][j] = mat_a_q[bank_q][i][j];
            act_b[i][j] = mat_b_q[bank_q][i][j];
         end
   end

   assign ready_d = 1'b1;
`else
   logic [data_size-1:0] mat_a_q [4][4];
   logic [data_size-1:0] mat_b_q [4][4];

   // Matrix writes: A row or B column, only while idle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
               mat_a_q[i][j] <= '0;
               mat_b_q[i][j] <= '0;
            end
      end else if (load_fire) begin
         for (int k = 0; k < 4; k++) begin
            if (!ld.load_sel) mat_a_q[ld.load_idx][k] <= ld.load_data[k*data_size +: data_size];
            else              mat_b_q[k][ld.load_idx] <= ld.load_data[k*data_size +: data_size];
         end
      end
   end

   // Single bank is always the streamed one
   always_comb begin
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            act_a[i][j] = mat_a_q[i][j];
            act_b[i][j] = mat_b_q[i][j];
         end
   end

   assign ready_d = (state_d == StIdle);
`endif

   // Next state and step counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StClear;
         StClear: begin
            state_d = StStream;
            cnt_d   = 3'd0;
         end
         StStream: begin
            if (cnt_q == 3'd6) begin
               state_d = StDrain;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StDrain: begin
            if (cnt_q == 3'd2) state_d = StDone;
            else               cnt_d = cnt_q + 3'd1;
         end
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Operand outputs for the upcoming cycle: element k-i of lane i, zero outside the window
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a_d[i] = '0;
         b_d[i] = '0;
         if (state_d == StStream && cnt_d >= 3'(i) && (cnt_d - 3'(i)) <= 3'd3) begin
            a_d[i] = act_a[i][2'(cnt_d - 3'(i))];
            b_d[i] = act_b[2'(cnt_d - 3'(i))][i];
         end
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         array_rst_q <= 1'b0;
         ready_q     <= 1'b1;
         for (int i = 0; i < 4; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= (state_d != StIdle);
         done_q      <= (state_d == StDone);
         array_rst_q <= (state_d == StClear);
         ready_q     <= ready_d;
         for (int i = 0; i < 4; i++) begin
            a_q[i] <= a_d[i];
            b_q[i] <= b_d[i];
         end
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign array_rst     = array_rst_q;
   assign ld.load_ready = ready_q;
   assign a1 = a_q[0];
   assign a2 = a_q[1];
   assign a3 = a_q[2];
   assign a4 = a_q[3];
   assign b1 = b_q[0];
   assign b2 = b_q[1];
   assign b3 = b_q[2];
   assign b4 = b_q[3];

endmodule
